// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signals of the load/store unit.
// The LSU takes the slave view; the pipeline plus memory take the master view.
interface load_store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic        mem_write_en;
   logic [31:0] mem_address;
   logic [31:0] mem_data_in;
   logic [31:0] mem_data_out;

   modport master (
      output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_data_out,
      input  req_ready, resp_valid, resp_rdata, resp_fault,
      input  mem_write_en, mem_address, mem_data_in
   );

   modport slave (
      input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_data_out,
      output req_ready, resp_valid, resp_rdata, resp_fault,
      output mem_write_en, mem_address, mem_data_in
   );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit for a word-only data memory: RV32I width/sign decode,
// read-modify-write for SB/SH, load extension and misalignment/illegal faults.
module load_store_unit (
   input logic              clk,
   input logic              rst_n,
   load_store_unit_if.slave bus
);
   typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

   state_e      state_q, state_d;
   logic        store_q;
   logic [2:0]  funct3_q;
   logic [1:0]  addr_q;
   logic [15:0] wdata_q;
   logic [31:0] rdata_q;
   logic        fault_q;
   logic [31:0] mem_addr_q;
   logic [31:0] mem_wdata_q;

   logic        accept;
   logic        legal;
   logic        misaligned;
   logic        fault_req;
   logic        is_sw;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [31:0] load_data;
   logic [31:0] merged;

   // Request decode, only meaningful while idle.
   always_comb begin
      accept = bus.req_valid && (state_q == StIdle);
      legal  = 1'b0;
      case (bus.req_funct3)
         3'd0, 3'd1, 3'd2: legal = 1'b1;
         3'd4, 3'd5:       legal = !bus.req_store;
         default:          legal = 1'b0;
      endcase
      misaligned = ((bus.req_funct3[1:0] == 2'd1) && bus.req_addr[0]) ||
                   ((bus.req_funct3[1:0] == 2'd2) && (bus.req_addr[1:0] != 2'd0));
      fault_req  = !legal || misaligned;
      is_sw      = bus.req_store && (bus.req_funct3[1:0] == 2'd2);
   end

   // Lane select/extension for loads and lane merge for sub-word stores.
   always_comb begin
      lane_b    = bus.mem_data_out[{addr_q, 3'b000} +: 8];
      lane_h    = addr_q[1] ? bus.mem_data_out[31:16] : bus.mem_data_out[15:0];
      load_data = bus.mem_data_out;
      case (funct3_q)
         3'd0:    load_data = {{24{lane_b[7]}}, lane_b};
         3'd1:    load_data = {{16{lane_h[15]}}, lane_h};
         3'd4:    load_data = {24'd0, lane_b};
         3'd5:    load_data = {16'd0, lane_h};
         default: load_data = bus.mem_data_out;
      endcase
      merged = bus.mem_data_out;
      if (funct3_q[1:0] == 2'd0) begin
         merged[{addr_q, 3'b000} +: 8] = wdata_q[7:0];
      end else begin
         merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (accept) begin
               if (fault_req)  state_d = StDone;
               else if (is_sw) state_d = StWrite;
               else            state_d = StRead;
            end
         end
         StRead:  state_d = store_q ? StWrite : StDone;
         StWrite: state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         store_q     <= 1'b0;
         funct3_q    <= 3'd0;
         addr_q      <= 2'd0;
         wdata_q     <= 16'd0;
         rdata_q     <= 32'd0;
         fault_q     <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_wdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            store_q  <= bus.req_store;
            funct3_q <= bus.req_funct3;
            addr_q   <= bus.req_addr[1:0];
            wdata_q  <= bus.req_wdata[15:0];
            if (fault_req) begin
               rdata_q <= 32'd0;
               fault_q <= 1'b1;
            end else begin
               mem_addr_q <= {bus.req_addr[31:2], 2'b00};
               if (is_sw) mem_wdata_q <= bus.req_wdata;
            end
         end
         if (state_q == StRead) begin
            if (store_q) begin
               mem_wdata_q <= merged;
            end else begin
               rdata_q <= load_data;
               fault_q <= 1'b0;
            end
         end
         if (state_q == StWrite) begin
            rdata_q <= 32'd0;
            fault_q <= 1'b0;
         end
      end
   end

   // Control outputs straight from state so they are stable across the memory's negedge.
   assign bus.req_ready    = (state_q == StIdle);
   assign bus.resp_valid   = (state_q == StDone);
   assign bus.resp_rdata   = rdata_q;
   assign bus.resp_fault   = fault_q;
   assign bus.mem_write_en = (state_q == StWrite);
   assign bus.mem_address  = mem_addr_q;
   assign bus.mem_data_in  = mem_wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: negedge word memory model, directed plus random requests
// checked against a byte-level reference model of the RV32I load/store rules.
module tb_load_store_unit;
   logic clk;
   logic rst_n;
   load_store_unit_if bus ();

   load_store_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] mem [256];
   logic [31:0] ref_mem [256];
   int n_vec = 0;
   int n_err = 0;
   int wr_total = 0;
   int resp_total = 0;
   int accept_cnt = 0;

   function automatic logic [31:0] init_word(input int i);
      if (i == 32'h20) return 32'hDEADBEEF;
      if (i == 32'h21) return 32'h0;
      return (i * 32'h9E3779B9) ^ 32'h5A5A5A5A;
   endfunction

   // Data memory: samples address/write on negedge, read data ready by next posedge.
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = init_word(i);
      bus.mem_data_out = 32'd0;
      forever begin
         @(negedge clk);
         if (bus.mem_write_en === 1'b1) begin
            mem[bus.mem_address[9:2]] = bus.mem_data_in;
            wr_total++;
         end
         if (bus.resp_valid === 1'b1) resp_total++;
         bus.mem_data_out = mem[bus.mem_address[9:2]];
      end
   end

   always @(posedge clk) begin
      if (bus.req_valid && bus.req_ready) accept_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic txn(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input bit hold,
                      output int resp_cyc, output logic [31:0] rd, output logic flt,
                      output int n_wr, output int wr_cyc, output logic [31:0] wr_data,
                      output logic [31:0] wr_addr);
      resp_cyc = -1; rd = 32'd0; flt = 1'b0;
      n_wr = 0; wr_cyc = -1; wr_data = 32'd0; wr_addr = 32'd0;
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_store  = st;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wd;
      for (int i = 0; i < 10 && bus.req_ready !== 1'b1; i++) @(negedge clk);
      @(posedge clk);
      #1;
      if (!hold) bus.req_valid = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (bus.mem_write_en === 1'b1) begin
            n_wr++;
            wr_cyc  = c;
            wr_data = bus.mem_data_in;
            wr_addr = bus.mem_address;
         end
         if (bus.resp_valid === 1'b1) begin
            resp_cyc = c;
            rd       = bus.resp_rdata;
            flt      = bus.resp_fault;
            break;
         end
      end
      bus.req_valid = 1'b0;
   endtask

   // Reference: legality, alignment, byte lanes and latency from plain arithmetic.
   task automatic run_check(input string tag, input logic st, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd, input bit hold,
                            output logic [31:0] rd_o);
      int size, lane, exp_cyc, exp_wr, exp_wr_cyc;
      int resp_cyc, n_wr, wr_cyc;
      bit legal, mis, fault;
      logic [31:0] word, exp_rd, new_word, mask, rd, wr_data, wr_addr;
      logic flt;
      size  = 1 << f3[1:0];
      legal = st ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 <= 3'd5);
      lane  = int'(addr[1:0]);
      mis   = (lane % size) != 0;
      fault = !legal || mis;
      word  = ref_mem[addr[9:2]];
      exp_rd = 32'd0;
      new_word = word;
      if (!fault && !st) begin
         exp_rd = word >> (8 * lane);
         if (size < 4) begin
            mask = (32'h1 << (8 * size)) - 32'h1;
            exp_rd = exp_rd & mask;
            if (!f3[2] && exp_rd[8 * size - 1]) exp_rd = exp_rd | ~mask;
         end
      end
      if (!fault && st) begin
         for (int b = 0; b < size; b++) new_word[8 * (lane + b) +: 8] = wd[8 * b +: 8];
      end
      exp_cyc    = fault ? 1 : ((st && size < 4) ? 3 : 2);
      exp_wr     = (!fault && st) ? 1 : 0;
      exp_wr_cyc = (size == 4) ? 1 : 2;

      txn(st, f3, addr, wd, hold, resp_cyc, rd, flt, n_wr, wr_cyc, wr_data, wr_addr);
      check({tag, ".resp_cycle"}, resp_cyc, exp_cyc);
      check({tag, ".rdata"}, rd, exp_rd);
      check({tag, ".fault"}, {31'd0, flt}, {31'd0, fault});
      check({tag, ".writes"}, n_wr, exp_wr);
      if (exp_wr == 1) begin
         check({tag, ".write_cycle"}, wr_cyc, exp_wr_cyc);
         check({tag, ".write_data"}, wr_data, new_word);
         check({tag, ".write_addr"}, wr_addr, {addr[31:2], 2'b00});
      end
      ref_mem[addr[9:2]] = new_word;
      check({tag, ".mem_word"}, mem[addr[9:2]], new_word);
      rd_o = rd;
   endtask

   initial begin
      logic [31:0] rd;
      int acc0, w0, r0;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
      rst_n = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_store = 1'b0;
      bus.req_funct3 = 3'd0;
      bus.req_addr = 32'd0;
      bus.req_wdata = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst.req_ready", {31'd0, bus.req_ready}, 32'd1);
      check("rst.resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      check("rst.resp_fault", {31'd0, bus.resp_fault}, 32'd0);
      check("rst.mem_write_en", {31'd0, bus.mem_write_en}, 32'd0);
      check("rst.resp_rdata", bus.resp_rdata, 32'd0);
      check("rst.mem_address", bus.mem_address, 32'd0);
      check("rst.mem_data_in", bus.mem_data_in, 32'd0);
      rst_n = 1'b1;

      run_check("lw80", 1'b0, 3'd2, 32'h80, 32'd0, 1'b0, rd);
      check("lw80.const", rd, 32'hDEADBEEF);
      run_check("lb83", 1'b0, 3'd0, 32'h83, 32'd0, 1'b0, rd);
      check("lb83.const", rd, 32'hFFFFFFDE);
      run_check("lbu83", 1'b0, 3'd4, 32'h83, 32'd0, 1'b0, rd);
      check("lbu83.const", rd, 32'h000000DE);
      run_check("lh82", 1'b0, 3'd1, 32'h82, 32'd0, 1'b0, rd);
      check("lh82.const", rd, 32'hFFFFDEAD);
      run_check("lhu80", 1'b0, 3'd5, 32'h80, 32'd0, 1'b0, rd);
      check("lhu80.const", rd, 32'h0000BEEF);
      run_check("lb80", 1'b0, 3'd0, 32'h80, 32'd0, 1'b0, rd);
      check("lb80.const", rd, 32'hFFFFFFEF);

      run_check("sb81", 1'b1, 3'd0, 32'h81, 32'hAAAAAA12, 1'b0, rd);
      run_check("lw80_after_sb", 1'b0, 3'd2, 32'h80, 32'd0, 1'b0, rd);
      check("lw80_after_sb.const", rd, 32'hDEAD12EF);
      run_check("sh86", 1'b1, 3'd1, 32'h86, 32'h1234CAFE, 1'b0, rd);
      check("sh86.word", mem[32'h21], 32'hCAFE0000);
      run_check("sw84", 1'b1, 3'd2, 32'h84, 32'h01234567, 1'b0, rd);
      run_check("lw84", 1'b0, 3'd2, 32'h84, 32'd0, 1'b0, rd);
      check("lw84.const", rd, 32'h01234567);

      run_check("flt_lw82", 1'b0, 3'd2, 32'h82, 32'd0, 1'b0, rd);
      run_check("flt_sh85", 1'b1, 3'd1, 32'h85, 32'h5555AAAA, 1'b0, rd);
      run_check("flt_f3_3", 1'b0, 3'd3, 32'h88, 32'd0, 1'b0, rd);
      run_check("flt_sbu", 1'b1, 3'd4, 32'h88, 32'h77, 1'b0, rd);

      acc0 = accept_cnt;
      run_check("hold_sb", 1'b1, 3'd0, 32'h8A, 32'h000000C3, 1'b1, rd);
      check("hold_sb.accepts", accept_cnt - acc0, 32'd1);
      acc0 = accept_cnt;
      run_check("hold_lh", 1'b0, 3'd1, 32'h8A, 32'd0, 1'b1, rd);
      check("hold_lh.accepts", accept_cnt - acc0, 32'd1);

      // Reset lands while an SB sits in READ.
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_store = 1'b1;
      bus.req_funct3 = 3'd0;
      bus.req_addr = 32'h91;
      bus.req_wdata = 32'h000000A5;
      for (int i = 0; i < 10 && bus.req_ready !== 1'b1; i++) @(negedge clk);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      w0 = wr_total;
      r0 = resp_total;
      @(negedge clk);
      check("rstmid.read_no_we", {31'd0, bus.mem_write_en}, 32'd0);
      rst_n = 1'b0;
      @(negedge clk);
      check("rstmid.req_ready", {31'd0, bus.req_ready}, 32'd1);
      check("rstmid.resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      check("rstmid.resp_fault", {31'd0, bus.resp_fault}, 32'd0);
      check("rstmid.mem_write_en", {31'd0, bus.mem_write_en}, 32'd0);
      check("rstmid.resp_rdata", bus.resp_rdata, 32'd0);
      check("rstmid.mem_address", bus.mem_address, 32'd0);
      check("rstmid.mem_data_in", bus.mem_data_in, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("rstmid.writes", wr_total - w0, 32'd0);
      check("rstmid.resps", resp_total - r0, 32'd0);
      check("rstmid.word", mem[32'h24], ref_mem[32'h24]);
      run_check("after_rst_lw90", 1'b0, 3'd2, 32'h90, 32'd0, 1'b0, rd);
      run_check("after_rst_sb91", 1'b1, 3'd0, 32'h91, 32'h0000005A, 1'b0, rd);

      for (int n = 0; n < 60; n++) begin
         run_check($sformatf("rand%0d", n), 1'($urandom_range(0, 1)),
                   3'($urandom_range(0, 7)), 32'($urandom_range(0, 255)), $urandom,
                   1'b0, rd);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
